id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath/immediate/PC width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 32, meaning stall-counter width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports: clk input 1 clock; rst input 1 synchronous active-high reset.
REQ-004 SHALL have ports: if_id_valid in 1, IF/ID holds an instruction; if_id_instr in 32, instruction word; if_id_pc in XLEN, its PC.
REQ-005 SHALL have ports: rs1_data, rs2_data in XLEN, register-file read data for the current rs1/rs2.
REQ-006 SHALL have ports: flush in 1, taken branch resolved in EX; ex_stall in 1, EX/MEM cannot accept.
REQ-007 SHALL have ports: pc_write out 1 and if_id_write out 1, fetch/IF-ID enables; stall_count out CNT_W, saturating load-use stall count.
REQ-008 SHALL have registered ID/EX ports: id_ex_valid 1; id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm XLEN; id_ex_rs1, id_ex_rs2, id_ex_rd 5; id_ex_funct3 3; id_ex_alu_op 4; id_ex_alu_src, id_ex_branch, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_reg_write, id_ex_illegal 1.

Function
REQ-009 SHALL decode R-type (0110011), load (0000011), OP-IMM (0010011), branch (1100011), store (0100011); any other opcode, or undefined funct3/funct7, sets illegal=1 with all other controls 0.
REQ-010 SHALL use alu_op: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, BGEU 0111, XOR 1001, BEQ 1010, BNE 1011, BLT 1100, BGE 1101, BLTU 1110.
REQ-011 SHALL add, beyond the previous decoder, distinct BLT/BGE/BLTU codes, SLT/SLTU are illegal, and loads/stores use ADD.
REQ-012 SHALL sign-extend I/S/B immediates from bit 31 to XLEN; B-immediate bit 0 is 0; R-type imm is 0.
REQ-013 SHALL force reg_write=0 when rd=x0.
REQ-014 SHALL treat rs1 as used for R, I, load, store, branch; rs2 only for R, store, branch.
REQ-015 SHALL detect load-use when if_id_valid & id_ex_valid & id_ex_mem_read & id_ex_rd!=0 & (used rs1 or used rs2 equals id_ex_rd).
REQ-016 SHALL register outputs per clock with priority: rst > flush > ex_stall > load-use > normal.
REQ-017 flush: SHALL load an ID/EX bubble (valid and all controls 0); pc_write=1, if_id_write=1; no stall counted.
REQ-018 ex_stall (no flush): SHALL hold ID/EX unchanged; pc_write=0, if_id_write=0; no stall counted.
REQ-019 load-use: SHALL load a bubble; pc_write=0, if_id_write=0; stall_count increments by 1, saturating at all-ones.
REQ-020 normal: SHALL load decoded fields; id_ex_valid=if_id_valid; pc_write=1, if_id_write=1.
REQ-021 SHALL generate pc_write and if_id_write combinationally in the same cycle as the condition.
REQ-022 SHALL give decode-to-ID/EX latency of exactly one cycle.
REQ-023 SHALL load a bubble when if_id_valid=0, with no hazard asserted.

Reset
REQ-024 On rst in a clock cycle, SHALL clear all ID/EX outputs and stall_count to 0 at that edge, overriding flush/stall.
REQ-025 SHALL drive pc_write=1 and if_id_write=1 while rst is high.

Structure
REQ-026 SHALL place opcode, alu_op and funct3 constants in a shared package (rv_pkg).
REQ-027 SHALL have one combinational sub-module, rv_decoder (instruction -> controls, imm, illegal, rs-used flags); hazard logic and registers stay in id_stage.

Verification
REQ-028 lw x5,0(x1)=0x0000A283 then add x6,x5,x2=0x00228333 -> one bubble, pc_write/if_id_write low one cycle, add issues next cycle, stall_count=1.
REQ-029 addi x1,x0,-1=0xFFF00093 -> next cycle id_ex_imm=all-ones, alu_op=0010, alu_src=1, reg_write=1, rd=1.
REQ-030 sw x2,8(x1)=0x0020A423 -> id_ex_imm=8, mem_write=1, reg_write=0, alu_op=0010.
REQ-031 0xFFFFFFFF -> id_ex_illegal=1, id_ex_valid=1, all other controls 0.
REQ-032 load-use with flush asserted the same cycle -> bubble, pc_write=1, stall_count unchanged; ex_stall 3 cycles -> ID/EX held 3 cycles.
REQ-033 rst asserted mid-stall -> all outputs and stall_count 0 next edge; run both XLEN=32 and XLEN=64.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Purpose  : Shared RISC-V decode constants for the ID stage: major opcodes,
//             funct3/funct7 encodings, ALU operation codes and the control
//             bundle carried from decode into the ID/EX register.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Major opcodes handled by the decoder
    localparam logic [6:0] c_OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

    // funct7 variants of the R-type / shift-immediate group
    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // Arithmetic / logic funct3
    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    // Load/store access-width funct3
    localparam logic [2:0] c_F3_MEM_B  = 3'b000;
    localparam logic [2:0] c_F3_MEM_H  = 3'b001;
    localparam logic [2:0] c_F3_MEM_W  = 3'b010;
    localparam logic [2:0] c_F3_MEM_D  = 3'b011;
    localparam logic [2:0] c_F3_MEM_BU = 3'b100;
    localparam logic [2:0] c_F3_MEM_HU = 3'b101;
    localparam logic [2:0] c_F3_MEM_WU = 3'b110;

    typedef enum logic [3:0] {
        c_ALU_AND  = 4'b0000,
        c_ALU_OR   = 4'b0001,
        c_ALU_ADD  = 4'b0010,
        c_ALU_SLL  = 4'b0011,
        c_ALU_SRL  = 4'b0100,
        c_ALU_SRA  = 4'b0101,
        c_ALU_SUB  = 4'b0110,
        c_ALU_BGEU = 4'b0111,
        c_ALU_XOR  = 4'b1001,
        c_ALU_BEQ  = 4'b1010,
        c_ALU_BNE  = 4'b1011,
        c_ALU_BLT  = 4'b1100,
        c_ALU_BGE  = 4'b1101,
        c_ALU_BLTU = 4'b1110
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    branch;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
        logic    illegal;
    } ctrl_t;

    // All-zero control word: used for bubbles and as the decoder default
    localparam ctrl_t c_CTRL_NOP = '{alu_op: c_ALU_AND, default: 1'b0};

endpackage
`default_nettype wire

// File: rtl/rv_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : rv_decoder
//  Purpose  : Purely combinational instruction decoder.
//  Ports    : i_instr     - 32-bit instruction word
//             o_ctrl      - control bundle (alu_op, alu_src, branch, mem_*,
//                           reg_write, illegal)
//             o_imm       - sign-extended immediate, XLEN wide
//             o_rs1/o_rs2/o_rd/o_funct3 - raw register and funct3 fields
//             o_rs1_used/o_rs2_used     - source operand actually read
//  Revision : 1.0 - initial release
// ============================================================================
module rv_decoder
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    output ctrl_t           o_ctrl,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [2:0]      o_funct3,
    output logic            o_rs1_used,
    output logic            o_rs2_used
);

    localparam bit c_RV64 = (XLEN == 64);

    logic [6:0]      w_opcode;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic            w_slli_ok;
    logic            w_sri_ok;
    logic            w_legal;

    assign w_opcode = i_instr[6:0];
    assign w_funct7 = i_instr[31:25];
    assign o_rd     = i_instr[11:7];
    assign o_funct3 = i_instr[14:12];
    assign o_rs1    = i_instr[19:15];
    assign o_rs2    = i_instr[24:20];

    assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};

    // RV64 shift amounts are 6 bits wide, so bit 25 belongs to shamt there;
    // on RV32 it must be zero.
    assign w_slli_ok = c_RV64 ? (i_instr[31:26] == 6'b000000)
                              : (w_funct7 == c_F7_BASE);
    assign w_sri_ok  = c_RV64 ? (i_instr[31:26] == 6'b000000 || i_instr[31:26] == 6'b010000)
                              : (w_funct7 == c_F7_BASE || w_funct7 == c_F7_ALT);

    always_comb begin
        o_ctrl     = c_CTRL_NOP;
        o_imm      = '0;
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
        w_legal    = 1'b1;

        case (w_opcode)
            c_OPC_RTYPE: begin
                o_ctrl.reg_write = 1'b1;
                o_rs1_used       = 1'b1;
                o_rs2_used       = 1'b1;
                if (w_funct7 == c_F7_BASE) begin
                    case (o_funct3)
                        c_F3_ADD: o_ctrl.alu_op = c_ALU_ADD;
                        c_F3_SLL: o_ctrl.alu_op = c_ALU_SLL;
                        c_F3_XOR: o_ctrl.alu_op = c_ALU_XOR;
                        c_F3_SR:  o_ctrl.alu_op = c_ALU_SRL;
                        c_F3_OR:  o_ctrl.alu_op = c_ALU_OR;
                        c_F3_AND: o_ctrl.alu_op = c_ALU_AND;
                        default:  w_legal = 1'b0;   // SLT/SLTU not supported
                    endcase
                end else if (w_funct7 == c_F7_ALT) begin
                    case (o_funct3)
                        c_F3_ADD: o_ctrl.alu_op = c_ALU_SUB;
                        c_F3_SR:  o_ctrl.alu_op = c_ALU_SRA;
                        default:  w_legal = 1'b0;
                    endcase
                end else begin
                    w_legal = 1'b0;
                end
            end

            c_OPC_OPIMM: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_rs1_used       = 1'b1;
                o_imm            = w_imm_i;
                case (o_funct3)
                    c_F3_ADD: o_ctrl.alu_op = c_ALU_ADD;
                    c_F3_XOR: o_ctrl.alu_op = c_ALU_XOR;
                    c_F3_OR:  o_ctrl.alu_op = c_ALU_OR;
                    c_F3_AND: o_ctrl.alu_op = c_ALU_AND;
                    c_F3_SLL: begin
                        o_ctrl.alu_op = c_ALU_SLL;
                        w_legal       = w_slli_ok;
                    end
                    c_F3_SR: begin
                        o_ctrl.alu_op = i_instr[30] ? c_ALU_SRA : c_ALU_SRL;
                        w_legal       = w_sri_ok;
                    end
                    default: w_legal = 1'b0;        // SLTI/SLTIU not supported
                endcase
            end

            c_OPC_LOAD: begin
                o_ctrl.alu_op     = c_ALU_ADD;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_rs1_used        = 1'b1;
                o_imm             = w_imm_i;
                case (o_funct3)
                    c_F3_MEM_B, c_F3_MEM_H, c_F3_MEM_W,
                    c_F3_MEM_BU, c_F3_MEM_HU: w_legal = 1'b1;
                    c_F3_MEM_D, c_F3_MEM_WU:  w_legal = c_RV64;
                    default:                  w_legal = 1'b0;
                endcase
            end

            c_OPC_STORE: begin
                o_ctrl.alu_op    = c_ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_rs1_used       = 1'b1;
                o_rs2_used       = 1'b1;
                o_imm            = w_imm_s;
                case (o_funct3)
                    c_F3_MEM_B, c_F3_MEM_H, c_F3_MEM_W: w_legal = 1'b1;
                    c_F3_MEM_D:                         w_legal = c_RV64;
                    default:                            w_legal = 1'b0;
                endcase
            end

            c_OPC_BRANCH: begin
                o_ctrl.branch = 1'b1;
                o_rs1_used    = 1'b1;
                o_rs2_used    = 1'b1;
                o_imm         = w_imm_b;
                case (o_funct3)
                    c_F3_BEQ:  o_ctrl.alu_op = c_ALU_BEQ;
                    c_F3_BNE:  o_ctrl.alu_op = c_ALU_BNE;
                    c_F3_BLT:  o_ctrl.alu_op = c_ALU_BLT;
                    c_F3_BGE:  o_ctrl.alu_op = c_ALU_BGE;
                    c_F3_BLTU: o_ctrl.alu_op = c_ALU_BLTU;
                    c_F3_BGEU: o_ctrl.alu_op = c_ALU_BGEU;
                    default:   w_legal = 1'b0;
                endcase
            end

            default: w_legal = 1'b0;
        endcase

        // Illegal encodings carry only the illegal flag; clearing the
        // rs-used flags keeps them from creating false load-use stalls.
        if (!w_legal) begin
            o_ctrl         = c_CTRL_NOP;
            o_ctrl.illegal = 1'b1;
            o_imm          = '0;
            o_rs1_used     = 1'b0;
            o_rs2_used     = 1'b0;
        end else if (o_rd == 5'd0) begin
            o_ctrl.reg_write = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : Instruction-decode pipeline stage with load-use hazard
//             detection and the ID/EX pipeline register.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             if_id_valid/instr/pc     - instruction held in IF/ID
//             rs1_data, rs2_data       - register-file read data
//             flush, ex_stall          - taken branch in EX / EX-MEM busy
//             pc_write, if_id_write    - fetch and IF/ID enables (comb.)
//             stall_count              - saturating load-use stall counter
//             id_ex_*                  - registered ID/EX contents
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_id_valid,
    input  logic [31:0]      if_id_instr,
    input  logic [XLEN-1:0]  if_id_pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    input  logic             ex_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [CNT_W-1:0] stall_count,
    output logic             id_ex_valid,
    output logic [XLEN-1:0]  id_ex_pc,
    output logic [XLEN-1:0]  id_ex_rs1_data,
    output logic [XLEN-1:0]  id_ex_rs2_data,
    output logic [XLEN-1:0]  id_ex_imm,
    output logic [4:0]       id_ex_rs1,
    output logic [4:0]       id_ex_rs2,
    output logic [4:0]       id_ex_rd,
    output logic [2:0]       id_ex_funct3,
    output logic [3:0]       id_ex_alu_op,
    output logic             id_ex_alu_src,
    output logic             id_ex_branch,
    output logic             id_ex_mem_read,
    output logic             id_ex_mem_write,
    output logic             id_ex_mem_to_reg,
    output logic             id_ex_reg_write,
    output logic             id_ex_illegal
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t           w_ctrl;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_load_use;
    logic            w_hold_front;
    logic            w_load_en;
    logic            w_take;

    ctrl_t            r_ctrl;
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [2:0]       r_funct3;
    logic [CNT_W-1:0] r_stall_count;

    rv_decoder #(
        .XLEN (XLEN)
    ) u_decoder (
        .i_instr    (if_id_instr),
        .o_ctrl     (w_ctrl),
        .o_imm      (w_imm),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2),
        .o_rd       (w_rd),
        .o_funct3   (w_funct3),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used)
    );

    assign w_load_use = if_id_valid && r_valid && r_ctrl.mem_read && (r_rd != 5'd0) &&
                        ((w_rs1_used && (w_rs1 == r_rd)) || (w_rs2_used && (w_rs2 == r_rd)));

    // Front end freezes only for a pipeline stall or a load-use bubble; reset
    // and flush both keep fetch running.
    assign w_hold_front = !rst && !flush && (ex_stall || w_load_use);
    assign pc_write     = !w_hold_front;
    assign if_id_write  = !w_hold_front;

    // ID/EX updates unless EX is stalled (a flush overrides the stall).
    // Everything other than a clean, valid, hazard-free instruction is a bubble.
    assign w_load_en = flush || !ex_stall;
    assign w_take    = !flush && !w_load_use && if_id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_ctrl        <= c_CTRL_NOP;
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_funct3      <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_load_en) begin
                r_valid    <= w_take;
                r_ctrl     <= w_take ? w_ctrl   : c_CTRL_NOP;
                r_pc       <= w_take ? if_id_pc : '0;
                r_rs1_data <= w_take ? rs1_data : '0;
                r_rs2_data <= w_take ? rs2_data : '0;
                r_imm      <= w_take ? w_imm    : '0;
                r_rs1      <= w_take ? w_rs1    : 5'd0;
                r_rs2      <= w_take ? w_rs2    : 5'd0;
                r_rd       <= w_take ? w_rd     : 5'd0;
                r_funct3   <= w_take ? w_funct3 : 3'd0;
            end
            if (!flush && !ex_stall && w_load_use && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + c_CNT_ONE;
            end
        end
    end

    assign stall_count      = r_stall_count;
    assign id_ex_valid      = r_valid;
    assign id_ex_pc         = r_pc;
    assign id_ex_rs1_data   = r_rs1_data;
    assign id_ex_rs2_data   = r_rs2_data;
    assign id_ex_imm        = r_imm;
    assign id_ex_rs1        = r_rs1;
    assign id_ex_rs2        = r_rs2;
    assign id_ex_rd         = r_rd;
    assign id_ex_funct3     = r_funct3;
    assign id_ex_alu_op     = r_ctrl.alu_op;
    assign id_ex_alu_src    = r_ctrl.alu_src;
    assign id_ex_branch     = r_ctrl.branch;
    assign id_ex_mem_read   = r_ctrl.mem_read;
    assign id_ex_mem_write  = r_ctrl.mem_write;
    assign id_ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign id_ex_reg_write  = r_ctrl.reg_write;
    assign id_ex_illegal    = r_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Directed self-checking bench for id_stage. An RV64 instance
//             (32-bit counter) and an RV32 instance (2-bit counter) share the
//             same stimulus; expected values are hand-computed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_id_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        ex_stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // ---------------- RV64 instance ----------------
    logic        a_pc_write, a_if_id_write, a_valid;
    logic [31:0] a_cnt;
    logic [63:0] a_pc, a_rs1_data, a_rs2_data, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_funct3;
    logic [3:0]  a_alu_op;
    logic        a_alu_src, a_branch, a_mem_read, a_mem_write, a_mem_to_reg, a_reg_write, a_illegal;

    id_stage #(.XLEN(64), .CNT_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(instr),
        .if_id_pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .ex_stall(ex_stall),
        .pc_write(a_pc_write), .if_id_write(a_if_id_write), .stall_count(a_cnt),
        .id_ex_valid(a_valid), .id_ex_pc(a_pc), .id_ex_rs1_data(a_rs1_data),
        .id_ex_rs2_data(a_rs2_data), .id_ex_imm(a_imm), .id_ex_rs1(a_rs1),
        .id_ex_rs2(a_rs2), .id_ex_rd(a_rd), .id_ex_funct3(a_funct3),
        .id_ex_alu_op(a_alu_op), .id_ex_alu_src(a_alu_src), .id_ex_branch(a_branch),
        .id_ex_mem_read(a_mem_read), .id_ex_mem_write(a_mem_write),
        .id_ex_mem_to_reg(a_mem_to_reg), .id_ex_reg_write(a_reg_write),
        .id_ex_illegal(a_illegal)
    );

    // ---------------- RV32 instance ----------------
    logic        b_pc_write, b_if_id_write, b_valid;
    logic [1:0]  b_cnt;
    logic [31:0] b_pc, b_rs1_data, b_rs2_data, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_funct3;
    logic [3:0]  b_alu_op;
    logic        b_alu_src, b_branch, b_mem_read, b_mem_write, b_mem_to_reg, b_reg_write, b_illegal;

    id_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(instr),
        .if_id_pc(pc[31:0]), .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]),
        .flush(flush), .ex_stall(ex_stall),
        .pc_write(b_pc_write), .if_id_write(b_if_id_write), .stall_count(b_cnt),
        .id_ex_valid(b_valid), .id_ex_pc(b_pc), .id_ex_rs1_data(b_rs1_data),
        .id_ex_rs2_data(b_rs2_data), .id_ex_imm(b_imm), .id_ex_rs1(b_rs1),
        .id_ex_rs2(b_rs2), .id_ex_rd(b_rd), .id_ex_funct3(b_funct3),
        .id_ex_alu_op(b_alu_op), .id_ex_alu_src(b_alu_src), .id_ex_branch(b_branch),
        .id_ex_mem_read(b_mem_read), .id_ex_mem_write(b_mem_write),
        .id_ex_mem_to_reg(b_mem_to_reg), .id_ex_reg_write(b_reg_write),
        .id_ex_illegal(b_illegal)
    );

    // Control word packed as {alu_op, alu_src, branch, mem_read, mem_write,
    // mem_to_reg, reg_write, illegal}
    logic [10:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_alu_op, a_alu_src, a_branch, a_mem_read, a_mem_write, a_mem_to_reg, a_reg_write, a_illegal};
    assign b_ctrl = {b_alu_op, b_alu_src, b_branch, b_mem_read, b_mem_write, b_mem_to_reg, b_reg_write, b_illegal};

    localparam logic [10:0] c_K_NONE   = 11'b0000_0000000;
    localparam logic [10:0] c_K_ADDI   = 11'b0010_1000010;
    localparam logic [10:0] c_K_SW     = 11'b0010_1001000;
    localparam logic [10:0] c_K_ILL    = 11'b0000_0000001;
    localparam logic [10:0] c_K_BLT    = 11'b1100_0100000;
    localparam logic [10:0] c_K_SUB    = 11'b0110_0000010;
    localparam logic [10:0] c_K_ADD    = 11'b0010_0000010;
    localparam logic [10:0] c_K_ADD_X0 = 11'b0010_0000000;
    localparam logic [10:0] c_K_LW     = 11'b0010_1010110;

    localparam logic [31:0] c_I_ADDI = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] c_I_SW   = 32'h0020A423;  // sw   x2,8(x1)
    localparam logic [31:0] c_I_ILL  = 32'hFFFFFFFF;
    localparam logic [31:0] c_I_BLT  = 32'hFE20CEE3;  // blt  x1,x2,-4
    localparam logic [31:0] c_I_SUB  = 32'h402081B3;  // sub  x3,x1,x2
    localparam logic [31:0] c_I_SLT  = 32'h0020A1B3;  // slt  x3,x1,x2
    localparam logic [31:0] c_I_ADD0 = 32'h00208033;  // add  x0,x1,x2
    localparam logic [31:0] c_I_LW   = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] c_I_ADD6 = 32'h00228333;  // add  x6,x5,x2

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Same expectation on both instances; the RV32 copy sees the low word.
    task automatic chk2(input string tag, input logic [63:0] o64, input logic [63:0] o32,
                        input logic [63:0] exp);
        chk({tag, "/x64"}, o64, exp);
        chk({tag, "/x32"}, o32, exp & 64'h0000_0000_FFFF_FFFF);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] p);
        if_id_valid = 1'b1;
        instr       = ins;
        pc          = p;
    endtask

    initial begin
        rst = 1'b1; if_id_valid = 1'b0; instr = 32'h0; pc = 64'h0;
        rs1_data = 64'h0; rs2_data = 64'h0; flush = 1'b0; ex_stall = 1'b0;

        // Reset state
        step();
        chk2("rst_valid", a_valid, b_valid, 0);
        chk2("rst_ctrl", a_ctrl, b_ctrl, c_K_NONE);
        chk2("rst_cnt", a_cnt, b_cnt, 0);
        chk2("rst_pc_write", a_pc_write, b_pc_write, 1);
        chk2("rst_if_id_write", a_if_id_write, b_if_id_write, 1);

        // Empty IF/ID gives a bubble with no hazard
        rst = 1'b0;
        step();
        chk2("idle_valid", a_valid, b_valid, 0);
        chk2("idle_pc_write", a_pc_write, b_pc_write, 1);

        // addi x1,x0,-1
        drive(c_I_ADDI, 64'h100);
        step();
        chk2("addi_valid", a_valid, b_valid, 1);
        chk2("addi_ctrl", a_ctrl, b_ctrl, c_K_ADDI);
        chk2("addi_imm", a_imm, b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk2("addi_rd", a_rd, b_rd, 1);
        chk2("addi_pc", a_pc, b_pc, 64'h100);

        // sw x2,8(x1) with register data pass-through
        drive(c_I_SW, 64'h8000_0000_0000_0104);
        rs1_data = 64'h1111_2222_3333_4444;
        rs2_data = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        chk2("sw_ctrl", a_ctrl, b_ctrl, c_K_SW);
        chk2("sw_imm", a_imm, b_imm, 8);
        chk2("sw_rs1_data", a_rs1_data, b_rs1_data, 64'h1111_2222_3333_4444);
        chk2("sw_rs2_data", a_rs2_data, b_rs2_data, 64'hAAAA_BBBB_CCCC_DDDD);
        chk2("sw_regs", {a_rs1, a_rs2, a_funct3}, {b_rs1, b_rs2, b_funct3}, {5'd1, 5'd2, 3'b010});
        chk2("sw_pc", a_pc, b_pc, 64'h8000_0000_0000_0104);

        // All-ones word is illegal but still valid
        drive(c_I_ILL, 64'h108);
        step();
        chk2("ill_valid", a_valid, b_valid, 1);
        chk2("ill_ctrl", a_ctrl, b_ctrl, c_K_ILL);
        chk2("ill_imm", a_imm, b_imm, 0);

        drive(c_I_BLT, 64'h10C);
        step();
        chk2("blt_ctrl", a_ctrl, b_ctrl, c_K_BLT);
        chk2("blt_imm", a_imm, b_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        drive(c_I_SUB, 64'h110);
        step();
        chk2("sub_ctrl", a_ctrl, b_ctrl, c_K_SUB);
        chk2("sub_imm", a_imm, b_imm, 0);

        drive(c_I_SLT, 64'h114);
        step();
        chk2("slt_ctrl", a_ctrl, b_ctrl, c_K_ILL);

        drive(c_I_ADD0, 64'h118);
        step();
        chk2("add_x0_ctrl", a_ctrl, b_ctrl, c_K_ADD_X0);

        // Load-use: lw x5 then add x6,x5,x2
        drive(c_I_LW, 64'h200);
        step();
        chk2("lw_ctrl", a_ctrl, b_ctrl, c_K_LW);
        chk2("lw_rd", a_rd, b_rd, 5);
        drive(c_I_ADD6, 64'h204);
        #1;
        chk2("lu_pc_write", a_pc_write, b_pc_write, 0);
        chk2("lu_if_id_write", a_if_id_write, b_if_id_write, 0);
        step();
        chk2("lu_bubble", a_valid, b_valid, 0);
        chk2("lu_bubble_ctrl", a_ctrl, b_ctrl, c_K_NONE);
        chk2("lu_cnt", a_cnt, b_cnt, 1);
        chk2("lu_release", a_pc_write, b_pc_write, 1);
        step();
        chk2("lu_issue_valid", a_valid, b_valid, 1);
        chk2("lu_issue_ctrl", a_ctrl, b_ctrl, c_K_ADD);
        chk2("lu_issue_rd", a_rd, b_rd, 6);

        // Load-use coinciding with flush: flush wins, nothing counted
        drive(c_I_LW, 64'h300);
        step();
        drive(c_I_ADD6, 64'h304);
        flush = 1'b1;
        #1;
        chk2("fl_pc_write", a_pc_write, b_pc_write, 1);
        chk2("fl_if_id_write", a_if_id_write, b_if_id_write, 1);
        step();
        flush = 1'b0;
        chk2("fl_bubble", a_valid, b_valid, 0);
        chk2("fl_cnt", a_cnt, b_cnt, 1);

        // ex_stall for three cycles holds ID/EX
        drive(c_I_ADDI, 64'h400);
        step();
        chk2("st_pre_rd", a_rd, b_rd, 1);
        drive(c_I_SW, 64'h404);
        ex_stall = 1'b1;
        #1;
        chk2("st_pc_write", a_pc_write, b_pc_write, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk2("st_hold_ctrl", a_ctrl, b_ctrl, c_K_ADDI);
            chk2("st_hold_pc", a_pc, b_pc, 64'h400);
        end
        chk2("st_cnt", a_cnt, b_cnt, 1);
        ex_stall = 1'b0;
        step();
        chk2("st_release_ctrl", a_ctrl, b_ctrl, c_K_SW);

        // Four more load-use stalls: RV64 counts to 5, 2-bit counter saturates at 3
        for (int i = 0; i < 4; i++) begin
            drive(c_I_LW, 64'h500);
            step();
            drive(c_I_ADD6, 64'h504);
            step();
            step();
        end
        chk("sat_cnt/x64", a_cnt, 5);
        chk("sat_cnt/x32", {62'b0, b_cnt}, 3);

        // Reset in the middle of a stall
        drive(c_I_LW, 64'h600);
        step();
        drive(c_I_ADD6, 64'h604);
        ex_stall = 1'b1;
        step();
        chk2("mid_hold_ctrl", a_ctrl, b_ctrl, c_K_LW);
        rst = 1'b1;
        #1;
        chk2("mid_rst_pc_write", a_pc_write, b_pc_write, 1);
        chk2("mid_rst_if_id_write", a_if_id_write, b_if_id_write, 1);
        step();
        chk2("mid_rst_valid", a_valid, b_valid, 0);
        chk2("mid_rst_ctrl", a_ctrl, b_ctrl, c_K_NONE);
        chk2("mid_rst_fields", {a_rd, a_rs1, a_rs2, a_funct3}, {b_rd, b_rs1, b_rs2, b_funct3}, 0);
        chk2("mid_rst_imm", a_imm, b_imm, 0);
        chk2("mid_rst_pc", a_pc, b_pc, 0);
        chk2("mid_rst_data", a_rs1_data | a_rs2_data, b_rs1_data | b_rs2_data, 0);
        chk2("mid_rst_cnt", a_cnt, b_cnt, 0);

        rst = 1'b0; ex_stall = 1'b0; if_id_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
